mult_8_seq: RTL

//  Unsigned 8x8 shift-and-add multiplier; multi-cycle unit beside the ALU.

---
 rtl/mult_8_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/mult_8_seq.sv
// mult_8_seq: unsigned WIDTH x WIDTH shift-and-add multiplier. It runs one
// partial-product step per cycle through an external combinational WIDTH-bit
// adder.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               request, accepted only while ready=1
//   multiplicand        operand A, latched on accept
//   multiplier          operand B, latched on accept
//   ready               1 while idle and able to accept
//   product             A*B, held from result_valid until the next result
//   result_valid        one-cycle pulse when product is final
//   add_x/add_y/add_c0  operands driven to the external adder
//   add_sum/add_c8      sum and carry-out returned by the external adder
//   dbg_state           current FSM state, for checkers
//
// Handshake: a request transfers on a rising edge where start=1 and ready=1.
// ready is low from the accept edge until the cycle after the result_valid
// pulse, so ready and result_valid are never high together. A start seen
// while ready=0 is ignored and is not queued.
module mult_8_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic [2*WIDTH-1:0] product,
  output logic               result_valid,
  output logic [WIDTH-1:0]   add_x,
  output logic [WIDTH-1:0]   add_y,
  output logic               add_c0,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_c8,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;

  // When the LSB is 0, the adder adds zero. The same datapath then does a
  // plain shift.
  assign add_x     = acc_hi;
  assign add_y     = mplier_reg[0] ? mcand_reg : '0;
  assign add_c0    = 1'b0;
  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      ready        <= 1'b1;
      result_valid <= 1'b0;
      product      <= '0;
      count        <= '0;
      acc_hi       <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ready && start) begin
            mcand_reg  <= multiplicand;
            mplier_reg <= multiplier;
            acc_hi     <= '0;
            count      <= '0;
            ready      <= 1'b0;
            state      <= S_RUN;
          end else begin
            // Also the path that raises ready the cycle after result_valid.
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          // Right shift of {carry, sum, multiplier}. The carry lands in the
          // MSB, so the accumulator never overflows.
          {acc_hi, mplier_reg} <= {add_c8, add_sum, mplier_reg[WIDTH-1:1]};
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          product      <= {acc_hi, mplier_reg};
          result_valid <= 1'b1;
          state        <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
